// File: rtl/mod_step_counter_pkg.sv
//------------------------------------------------------------------------------
// Module  : counter_pkg
// Brief   : Shared types and default widths for the step counter
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

   // Overflow policy for the step counter
   typedef enum logic {
      OVF_WRAP = 1'b0,
      OVF_SAT  = 1'b1
   } ovf_mode_e;

   localparam int COUNTER_W = 8;
   localparam int STEP_W    = 4;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/mod_step_counter_step_adder.sv
//------------------------------------------------------------------------------
// Module  : Full_Adder / step_adder
// Brief   : One-bit full adder cell and a WIDTH+1 bit ripple add/subtract of
//           a zero-extended step
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module Full_Adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : Full_Adder

module step_adder #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0]  i_a,
   input  logic [STEP_W-1:0] i_step,
   input  logic              i_sub,
   output logic [WIDTH:0]    o_sum,
   output logic              o_carry
);

   import counter_pkg::*;

   // Operands are widened by one bit so an up-count carry lands in o_sum[WIDTH]
   logic [WIDTH:0] w_a;
   logic [WIDTH:0] w_b;
   logic [WIDTH+1:0] w_c;

   assign w_a    = {1'b0, i_a};
   // Subtraction is a + ~b + 1; the carry-in supplies the +1
   assign w_b    = {{(WIDTH+1-STEP_W){1'b0}}, i_step} ^ {(WIDTH+1){i_sub}};
   assign w_c[0] = i_sub;

   generate
      for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
         Full_Adder u_fa (
            .i_a    (w_a[g]),
            .i_b    (w_b[g]),
            .i_cin  (w_c[g]),
            .o_sum  (o_sum[g]),
            .o_cout (w_c[g+1])
         );
      end
   endgenerate

   // On subtract, carry-out low means a borrow (i_a < step)
   assign o_carry = w_c[WIDTH+1];

endmodule : step_adder

`default_nettype wire

// File: rtl/mod_step_counter.sv
//------------------------------------------------------------------------------
// Module  : mod_step_counter
// Brief   : Modulo up/down counter with programmable limit, step, load and
//           wrap/saturate overflow policy
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_step_counter #(
   parameter int WIDTH  = counter_pkg::COUNTER_W,
   parameter int STEP_W = counter_pkg::STEP_W
) (
   input  logic              i_clk,
   input  logic              i_RESET_n,
   input  logic              i_en,
   input  logic              i_up,
   input  logic              i_mode,
   input  logic [STEP_W-1:0] i_step,
   input  logic [WIDTH-1:0]  i_limit,
   input  logic              i_load,
   input  logic [WIDTH-1:0]  i_load_val,
   output logic [WIDTH-1:0]  o_count,
   output logic              o_ovf,
   output logic              o_at_max,
   output logic              o_at_min
);

   import counter_pkg::*;

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic [WIDTH:0]   w_sum;
   logic             w_carry;
   logic             w_up_ovf;
   logic             w_dn_unf;
   logic [WIDTH-1:0] w_load_clamped;
   ovf_mode_e        w_mode;

   assign w_mode = ovf_mode_e'(i_mode);

   step_adder #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_step_adder (
      .i_a     (r_count),
      .i_step  (i_step),
      .i_sub   (~i_up),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   // Up overflow compares the full WIDTH+1 bit sum so the carry-out counts
   assign w_up_ovf       = w_sum > {1'b0, i_limit};
   assign w_dn_unf       = ~w_carry;
   assign w_load_clamped = (i_load_val > i_limit) ? i_limit : i_load_val;

   // Count register: reset > load > enable > hold
   always_ff @(posedge i_clk or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (i_load) begin
         r_count <= w_load_clamped;
         r_ovf   <= 1'b0;
      end else if (i_en) begin
         if (i_up && w_up_ovf) begin
            r_count <= (w_mode == OVF_SAT) ? i_limit : '0;
            r_ovf   <= 1'b1;
         end else if (!i_up && w_dn_unf) begin
            r_count <= (w_mode == OVF_SAT) ? '0 : i_limit;
            r_ovf   <= 1'b1;
         end else begin
            r_count <= w_sum[WIDTH-1:0];
            r_ovf   <= 1'b0;
         end
      end else begin
         r_ovf <= 1'b0;
      end
   end

   assign o_count  = r_count;
   assign o_ovf    = r_ovf;
   assign o_at_max = (r_count == i_limit);
   assign o_at_min = (r_count == '0);

endmodule : mod_step_counter

`default_nettype wire

// File: tb/tb_mod_step_counter.sv
//------------------------------------------------------------------------------
// Module  : tb_mod_step_counter
// Brief   : Directed self-checking bench for mod_step_counter
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_step_counter;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;

   logic              clk;
   logic              rst_n;
   logic              en;
   logic              up;
   logic              mode;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  limit;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  count;
   logic              ovf;
   logic              at_max;
   logic              at_min;

   int tests_run;
   int tests_failed;

   mod_step_counter #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) dut (
      .i_clk      (clk),
      .i_RESET_n  (rst_n),
      .i_en       (en),
      .i_up       (up),
      .i_mode     (mode),
      .i_step     (step),
      .i_limit    (limit),
      .i_load     (load),
      .i_load_val (load_val),
      .o_count    (count),
      .o_ovf      (ovf),
      .o_at_max   (at_max),
      .o_at_min   (at_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      mode     = 1'b0;
      step     = 4'd1;
      limit    = 8'd9;
      load     = 1'b0;
      load_val = 8'd0;

      // 1. Reset: get off zero, then assert reset mid-cycle
      #12 rst_n = 1'b1;
      tick();
      en = 1'b1;
      tick();
      tick();
      check("pre_reset_count", count, 2);
      #3 rst_n = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_ovf", ovf, 0);
      check("rst_at_min", at_min, 1);
      check("rst_at_max", at_max, 0);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_hold", count, 0);

      // 2. Up WRAP with limit 9, step 1
      en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("wrap_count", count, k % 10);
         check("wrap_ovf", ovf, (k % 10) == 0);
         check("wrap_at_max", at_max, (k % 10) == 9);
      end
      en = 1'b0;
      tick();
      check("hold_count", count, 2);
      check("hold_ovf", ovf, 0);

      // 3. Large step overflow, load clamps to limit
      limit = 8'd200; step = 4'd15; load = 1'b1; load_val = 8'd250;
      tick();
      check("load_clamp", count, 200);
      load = 1'b0; en = 1'b1; mode = 1'b1;
      tick();
      check("sat_up_count", count, 200);
      check("sat_up_ovf", ovf, 1);
      mode = 1'b0;
      tick();
      check("wrap_up_count", count, 0);
      check("wrap_up_ovf", ovf, 1);

      // 4. Down SAT from 5 by 3
      en = 1'b0; load = 1'b1; load_val = 8'd5;
      tick();
      check("load5", count, 5);
      load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd3; mode = 1'b1;
      tick();
      check("dn_count_2", count, 2);
      check("dn_ovf_0", ovf, 0);
      tick();
      check("dn_sat_count", count, 0);
      check("dn_sat_ovf", ovf, 1);
      tick();
      check("dn_sat_again", count, 0);
      check("dn_sat_ovf2", ovf, 1);
      check("dn_at_min", at_min, 1);
      mode = 1'b0;
      tick();
      check("dn_wrap_count", count, 200);
      check("dn_wrap_ovf", ovf, 1);

      // 5. Load beats enable; zero step holds
      load = 1'b1; load_val = 8'd7;
      tick();
      check("prio_count", count, 7);
      check("prio_ovf", ovf, 0);
      load = 1'b0; step = 4'd0;
      tick();
      check("zero_step_count", count, 7);
      check("zero_step_ovf", ovf, 0);

      // 6. Limit lowered below count
      en = 1'b0; load = 1'b1; load_val = 8'd50;
      tick();
      load = 1'b0; limit = 8'd20; up = 1'b1; step = 4'd1; mode = 1'b0; en = 1'b1;
      tick();
      check("shrink_wrap", count, 0);
      check("shrink_wrap_ovf", ovf, 1);
      en = 1'b0; limit = 8'd200; load = 1'b1;
      tick();
      load = 1'b0; limit = 8'd20; mode = 1'b1; en = 1'b1;
      tick();
      check("shrink_sat", count, 20);
      check("shrink_sat_ovf", ovf, 1);
      en = 1'b0; limit = 8'd200; load = 1'b1;
      tick();
      load = 1'b0; limit = 8'd20; up = 1'b0; en = 1'b1;
      tick();
      check("shrink_down", count, 49);
      check("shrink_down_ovf", ovf, 0);

      // Limit zero: stays at zero, pulses on each nonzero step
      limit = 8'd0; up = 1'b1; mode = 1'b0; load = 1'b1; load_val = 8'd3;
      tick();
      check("lim0_load", count, 0);
      load = 1'b0;
      tick();
      check("lim0_count", count, 0);
      check("lim0_ovf", ovf, 1);
      check("lim0_at_max", at_max, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mod_step_counter

`default_nettype wire

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
Parametrised successor to the fixed 8-bit registered incrementer. It is a WIDTH-bit modulo counter with programmable limit, step, direction, load and overflow policy. Overflow policy is either wrap or saturate. It serves as the general-purpose counter and timer primitive for address generators, baud dividers and event counters. Arithmetic uses a ripple step adder built from the existing half/full adder cells.

Parameters:
WIDTH, 8, counter, limit and load width in bits (>=2)
STEP_W, 4, step input width in bits (1..WIDTH)

Ports:
i_clk  in  1  rising-edge clock
i_RESET_n  in  1  reset, asynchronous assert, active-low
i_en  in  1  count enable; one step per cycle while high
i_up  in  1  direction: 1 = up, 0 = down
i_mode  in  1  overflow policy: 0 = WRAP, 1 = SAT (counter_pkg::ovf_mode_e)
i_step  in  STEP_W  increment/decrement amount
i_limit  in  WIDTH  inclusive upper bound; count range is 0..i_limit
i_load  in  1  synchronous load strobe
i_load_val  in  WIDTH  value loaded when i_load=1
o_count  out  WIDTH  registered count
o_ovf  out  1  registered one-cycle pulse: overflow/underflow occurred on the last update
o_at_max  out  1  o_count == i_limit (combinational from register)
o_at_min  out  1  o_count == 0 (combinational from register)

Behaviour:
- One clock, i_clk. Reset is asynchronous, active-low: i_RESET_n=0 immediately forces o_count=0 and o_ovf=0. Hence o_at_min=1, and o_at_max=(i_limit==0).
- Reset release is synchronous to i_clk. The first update can occur on the first rising edge with i_RESET_n=1.
- Reset mid-operation aborts the current step with no ovf pulse. Counting resumes from 0.
- Priority per edge is reset > load > enable > hold.
- Load: o_count <= min(i_load_val, i_limit); o_ovf <= 0. The load is taken regardless of i_en.
- Hold (i_en=0, i_load=0): o_count unchanged; o_ovf <= 0.
- Step adder: sum = {1'b0,o_count} +/- zero-extended i_step, computed at WIDTH+1 bits. Latency is 1 cycle from input to o_count.
- Up overflow: condition is sum > i_limit, which includes the WIDTH-bit carry-out.
  - WRAP: o_count <= 0.
  - SAT: o_count <= i_limit.
  - o_ovf <= 1 in both modes.
- Down underflow: condition is o_count < i_step.
  - WRAP: o_count <= i_limit.
  - SAT: o_count <= 0.
  - o_ovf <= 1 in both modes.
- Otherwise o_count <= sum[WIDTH-1:0] and o_ovf <= 0.
- SAT at the boundary re-asserts o_ovf every enabled cycle that would cross the limit. This holds when the counter is already at the limit, e.g. at i_limit counting up with step>0.
- i_step=0 with i_en=1: count holds, o_ovf=0.
- i_limit lowered below the current o_count:
  - Counting up: next enabled step overflows (WRAP->0, SAT->i_limit).
  - Counting down: normal decrement, no clamp until a step.
- i_limit=0: counter stays 0. Every enabled nonzero step pulses o_ovf.
- i_up, i_mode, i_step and i_limit are sampled every edge with no internal registration. Changes take effect on the next edge.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {OVF_WRAP=1'b0, OVF_SAT=1'b1} ovf_mode_e
  - localparam defaults COUNTER_W=8 and STEP_W=4
- One sub-module, step_adder #(WIDTH, STEP_W):
  - Combinational WIDTH+1-bit add/subtract of a zero-extended step, built as a generate chain of Full_Adder cells.
  - Subtract uses inverted operand and carry-in=1.
  - Outputs sum and borrow/carry.
- The top-level block holds the register, the priority mux, the limit compare and the flags.

Test Plan:
1. Reset: assert i_RESET_n=0 asynchronously mid-cycle -> o_count=0 and o_ovf=0 before the next edge; with i_limit=9, o_at_min=1 and o_at_max=0.
2. Up WRAP: WIDTH=8, i_limit=9, i_step=1, i_en=1 for 12 cycles -> counts 1..9, 0, 1, 2; o_ovf high only on the cycle o_count returns to 0; o_at_max high while at 9.
3. Step overflow: i_limit=200, i_step=15, load 250 -> loads 200. One step in SAT -> 200 with o_ovf=1. One step in WRAP -> 0 with o_ovf=1.
4. Down SAT: load 5, i_up=0, i_step=3 -> 2, then 0 with o_ovf=1, then 0 with o_ovf=1 again; o_at_min=1.
5. Priority: i_load=1, i_en=1, i_load_val=7 -> o_count=7 and o_ovf=0. Then i_step=0 with i_en=1 -> holds 7 and o_ovf=0.
6. Limit shrink: count at 50, set i_limit=20, step up in WRAP -> 0 with o_ovf=1. Repeat in SAT -> 20.
